ocx_tlx_data_route_n: RTL and testbench



---
 rtl/ocx_tlx_data_route_n.sv | 101 ++++++++++
 tb/tb_ocx_tlx_data_route_n.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocx_tlx_data_route_n.sv
// ocx_tlx_data_route_n: buffers parser data flits until a good-CRC bookend commits them, then routes committed flits to NUM_CH channels per queued route entries (in: flits/bookend/crc/route/ch_hold; out: route_ready, one-hot out_ch_v+out_data, flush status, sticky err)
module ocx_tlx_data_route_n #(
  parameter int FLIT_W    = 512,
  parameter int NUM_CH    = 2,
  parameter int CH_IDX_W  = 1,
  parameter int BUF_DEPTH = 16,
  parameter int RQ_DEPTH  = 8
) (
  input  logic                tlx_clk,
  input  logic                reset,
  input  logic                pars_data_valid,
  input  logic [FLIT_W-1:0]   pars_data_flit,
  input  logic                bookend_v,
  input  logic                crc_error,
  input  logic                route_v,
  input  logic [CH_IDX_W-1:0] route_ch,
  input  logic [1:0]          route_cnt,
  output logic                route_ready,
  input  logic [NUM_CH-1:0]   ch_hold,
  output logic [NUM_CH-1:0]   out_ch_v,
  output logic [FLIT_W-1:0]   out_data,
  output logic                flush_inprog,
  output logic                flush_done,
  output logic [2:0]          err
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int RW = $clog2(RQ_DEPTH);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [FLIT_W-1:0] flit_mem [BUF_DEPTH];
  logic [CH_IDX_W+1:0] rq_mem [RQ_DEPTH];
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, occ, committed;
  logic [RW:0] rq_wr, rq_rd, rq_cnt;
  logic [CH_IDX_W-1:0] cur_ch;
  logic [2:0] remaining;
  logic full, wr_en, rq_empty, take_direct, push, pop, beat, last;
  logic [CH_IDX_W+1:0] head;
  assign occ         = wr_ptr - rd_ptr;
  assign committed   = commit_ptr - rd_ptr;
  assign full        = occ[AW];
  assign wr_en       = pars_data_valid && !flush_inprog && !crc_error && !full;
  assign rq_cnt      = rq_wr - rq_rd;
  assign route_ready = !rq_cnt[RW];
  assign rq_empty    = rq_cnt == '0;
  // an entry arriving at an idle FSM with an empty queue bypasses the FIFO
  assign take_direct = state == IDLE && rq_empty && route_v;
  assign push        = route_v && route_ready && !take_direct;
  assign beat        = state == XFER && committed != '0 && !ch_hold[cur_ch];
  assign last        = beat && remaining == 3'd1;
  assign pop         = !rq_empty && (state == IDLE || last);
  assign head        = rq_mem[rq_rd[RW-1:0]];
  always_ff @(posedge tlx_clk) begin
    if (wr_en) flit_mem[wr_ptr[AW-1:0]] <= pars_data_flit;
    if (push) rq_mem[rq_wr[RW-1:0]] <= {route_ch, route_cnt};
  end
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      rq_wr        <= '0;
      rq_rd        <= '0;
      cur_ch       <= '0;
      remaining    <= '0;
      out_ch_v     <= '0;
      out_data     <= '0;
      flush_inprog <= 1'b0;
      flush_done   <= 1'b0;
      err          <= '0;
    end else begin
      flush_done <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (crc_error) begin
        wr_ptr       <= commit_ptr;
        flush_inprog <= 1'b1;
      end else if (bookend_v && flush_inprog) begin
        flush_inprog <= 1'b0;
        flush_done   <= 1'b1;
      end else if (bookend_v) commit_ptr <= wr_ptr + {{AW{1'b0}}, wr_en};
      if (pars_data_valid && !flush_inprog && !crc_error && full) err[0] <= 1'b1;
      if (route_v && !route_ready) err[1] <= 1'b1;
      if (pars_data_valid && bookend_v) err[2] <= 1'b1;
      if (push) rq_wr <= rq_wr + 1'b1;
      if (pop) rq_rd <= rq_rd + 1'b1;
      if (beat) rd_ptr <= rd_ptr + 1'b1;
      out_ch_v <= beat ? NUM_CH'(1) << cur_ch : '0;
      if (beat) out_data <= flit_mem[rd_ptr[AW-1:0]];
      if (pop) begin
        state     <= XFER;
        cur_ch    <= head[CH_IDX_W+1:2];
        remaining <= {1'b0, head[1:0]} + 3'd1;
      end else if (take_direct) begin
        state     <= XFER;
        cur_ch    <= route_ch;
        remaining <= {1'b0, route_cnt} + 3'd1;
      end else if (last) state <= IDLE;
      else if (beat) remaining <= remaining - 3'd1;
    end
  end
endmodule

// File: tb/tb_ocx_tlx_data_route_n.sv
// tb_ocx_tlx_data_route_n: randomized and directed bench for ocx_tlx_data_route_n with an in-order delivery scoreboard
module tb_ocx_tlx_data_route_n;
  localparam int FLIT_W = 512;
  localparam int NUM_CH = 2;
  localparam int CH_IDX_W = 1;
  logic tlx_clk = 0, reset = 1;
  logic pars_data_valid = 0, bookend_v = 0, crc_error = 0, route_v = 0;
  logic [FLIT_W-1:0] pars_data_flit = '0;
  logic [CH_IDX_W-1:0] route_ch = '0;
  logic [1:0] route_cnt = '0;
  logic route_ready;
  logic [NUM_CH-1:0] ch_hold = '0, out_ch_v;
  logic [FLIT_W-1:0] out_data;
  logic flush_inprog, flush_done;
  logic [2:0] err;
  int checks = 0, failures = 0, cyc = 0, n_fd = 0;
  bit rand_hold = 0;
  logic [NUM_CH-1:0] exp_ch [$];
  logic [FLIT_W-1:0] exp_d [$];
  int obs_t [$];

  ocx_tlx_data_route_n dut (
    .tlx_clk(tlx_clk), .reset(reset), .pars_data_valid(pars_data_valid),
    .pars_data_flit(pars_data_flit), .bookend_v(bookend_v), .crc_error(crc_error),
    .route_v(route_v), .route_ch(route_ch), .route_cnt(route_cnt),
    .route_ready(route_ready), .ch_hold(ch_hold), .out_ch_v(out_ch_v),
    .out_data(out_data), .flush_inprog(flush_inprog), .flush_done(flush_done), .err(err)
  );

  always #5 tlx_clk = ~tlx_clk;
  always @(posedge tlx_clk) cyc <= cyc + 1;

  always @(negedge tlx_clk) begin
    logic [NUM_CH-1:0] e_ch;
    logic [FLIT_W-1:0] e_d;
    if (!reset) begin
      if (flush_done) n_fd++;
      if (out_ch_v != '0) begin
        obs_t.push_back(cyc);
        checks++;
        if (exp_ch.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output ch=%b data=%h", out_ch_v, out_data[31:0]);
        end else begin
          e_ch = exp_ch.pop_front();
          e_d = exp_d.pop_front();
          if (out_ch_v !== e_ch || out_data !== e_d) begin
            failures++;
            $display("FAIL delivery got ch=%b data=%h want ch=%b data=%h", out_ch_v, out_data[31:0], e_ch, e_d[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic step;
    @(posedge tlx_clk);
    #1;
    pars_data_valid = 0;
    bookend_v = 0;
    crc_error = 0;
    route_v = 0;
    if (rand_hold) ch_hold = NUM_CH'($urandom);
  endtask

  task automatic push_flit(input logic [FLIT_W-1:0] d);
    pars_data_valid = 1;
    pars_data_flit = d;
    step();
  endtask

  task automatic push_route(input int ch, input int cnt);
    route_v = 1;
    route_ch = CH_IDX_W'(ch);
    route_cnt = 2'(cnt);
    step();
  endtask

  task automatic commit;
    bookend_v = 1;
    step();
  endtask

  task automatic add_exp(input int ch, input logic [FLIT_W-1:0] d);
    exp_ch.push_back(NUM_CH'(1) << ch);
    exp_d.push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_ch.size() != 0; i++) step();
    repeat (4) step();
  endtask

  function automatic logic [FLIT_W-1:0] rnd_flit();
    return {16{$urandom}};
  endfunction

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge tlx_clk);
    #1 reset = 0;
    checks += 6;
    if (out_ch_v !== '0) begin failures++; $display("FAIL reset_out_ch_v got %b want 0", out_ch_v); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got %h want 0", out_data[31:0]); end
    if (flush_inprog !== 1'b0) begin failures++; $display("FAIL reset_flush_inprog got %b want 0", flush_inprog); end
    if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
    if (err !== 3'b000) begin failures++; $display("FAIL reset_err got %b want 000", err); end
    if (route_ready !== 1'b1) begin failures++; $display("FAIL reset_route_ready got %b want 1", route_ready); end
    step();
  endtask

  task automatic test_commit_deliver;
    int s, b;
    s = obs_t.size();
    push_route(1, 1);
    push_flit(FLIT_W'('hA));
    push_flit(FLIT_W'('hB));
    add_exp(1, FLIT_W'('hA));
    add_exp(1, FLIT_W'('hB));
    commit();
    b = cyc;
    wait_drain(20);
    checks += 3;
    if (exp_ch.size() != 0) begin failures++; $display("FAIL commit_drain pending=%0d want 0", exp_ch.size()); end
    if (obs_t.size() < s + 2) begin failures++; $display("FAIL commit_count got %0d want 2", obs_t.size() - s); end
    else if (obs_t[s] != b + 1 || obs_t[s+1] != b + 2) begin
      failures++;
      $display("FAIL commit_latency got %0d,%0d want %0d,%0d", obs_t[s] - b, obs_t[s+1] - b, 1, 2);
    end
  endtask

  task automatic test_crc_flush;
    int s;
    logic [FLIT_W-1:0] d;
    n_fd = 0;
    push_route(0, 3);
    repeat (3) push_flit(rnd_flit());
    crc_error = 1;
    step();
    checks++;
    if (flush_inprog !== 1'b1) begin failures++; $display("FAIL crc_flush_inprog got %b want 1", flush_inprog); end
    repeat (2) push_flit(rnd_flit());
    commit();
    checks += 2;
    if (flush_done !== 1'b1) begin failures++; $display("FAIL crc_flush_done got %b want 1", flush_done); end
    if (flush_inprog !== 1'b0) begin failures++; $display("FAIL crc_flush_end got %b want 0", flush_inprog); end
    s = obs_t.size();
    repeat (6) step();
    checks += 2;
    if (obs_t.size() != s) begin failures++; $display("FAIL crc_discard got %0d outputs want 0", obs_t.size() - s); end
    if (n_fd != 1) begin failures++; $display("FAIL crc_flush_done_pulses got %0d want 1", n_fd); end
    for (int i = 0; i < 4; i++) begin
      d = rnd_flit();
      add_exp(0, d);
      push_flit(d);
    end
    commit();
    wait_drain(20);
    checks++;
    if (exp_ch.size() != 0) begin failures++; $display("FAIL crc_after_drain pending=%0d want 0", exp_ch.size()); end
  endtask

  task automatic test_hold;
    int s;
    logic [FLIT_W-1:0] d;
    s = obs_t.size();
    push_route(0, 3);
    for (int i = 0; i < 4; i++) begin
      d = rnd_flit();
      add_exp(0, d);
      push_flit(d);
    end
    commit();
    step();
    step();
    ch_hold[0] = 1;
    repeat (3) step();
    ch_hold[0] = 0;
    wait_drain(20);
    checks++;
    if (obs_t.size() != s + 4) begin failures++; $display("FAIL hold_count got %0d want 4", obs_t.size() - s); end
    else if (obs_t[s+1] - obs_t[s] != 1 || obs_t[s+2] - obs_t[s+1] != 4 || obs_t[s+3] - obs_t[s+2] != 1) begin
      failures++;
      $display("FAIL hold_gaps got %0d,%0d,%0d want 1,4,1", obs_t[s+1] - obs_t[s], obs_t[s+2] - obs_t[s+1], obs_t[s+3] - obs_t[s+2]);
    end
  endtask

  task automatic test_back_to_back;
    int s, b;
    logic [FLIT_W-1:0] d;
    s = obs_t.size();
    push_route(0, 0);
    push_route(1, 2);
    for (int i = 0; i < 4; i++) begin
      d = rnd_flit();
      add_exp(i == 0 ? 0 : 1, d);
      push_flit(d);
    end
    commit();
    b = cyc;
    wait_drain(20);
    checks++;
    if (obs_t.size() != s + 4) begin failures++; $display("FAIL b2b_count got %0d want 4", obs_t.size() - s); end
    else if (obs_t[s] != b + 1 || obs_t[s+3] != b + 4) begin
      failures++;
      $display("FAIL b2b_timing got first=%0d last=%0d want 1,4", obs_t[s] - b, obs_t[s+3] - b);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 20; it++) begin
      int nr, ch, cnt;
      logic [FLIT_W-1:0] data_q [$];
      logic [FLIT_W-1:0] d;
      nr = $urandom_range(1, 3);
      for (int r = 0; r < nr; r++) begin
        ch = $urandom_range(0, NUM_CH - 1);
        cnt = $urandom_range(0, 3);
        for (int j = 0; j <= cnt; j++) begin
          d = rnd_flit();
          add_exp(ch, d);
          data_q.push_back(d);
        end
        push_route(ch, cnt);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) push_flit(rnd_flit());
        crc_error = 1;
        step();
        if ($urandom_range(0, 1) == 1) push_flit(rnd_flit());
        commit();
      end
      rand_hold = 1;
      foreach (data_q[i]) begin
        push_flit(data_q[i]);
        if ($urandom_range(0, 2) == 0) commit();
      end
      commit();
      wait_drain(300);
      rand_hold = 0;
      ch_hold = '0;
      checks++;
      if (exp_ch.size() != 0) begin
        failures++;
        $display("FAIL random_drain iter=%0d pending=%0d want 0", it, exp_ch.size());
        exp_ch.delete();
        exp_d.delete();
      end
    end
  endtask

  task automatic test_overflow_wrap;
    logic [FLIT_W-1:0] d;
    logic [FLIT_W-1:0] q [$];
    for (int i = 0; i < 16; i++) begin
      d = rnd_flit();
      q.push_back(d);
      push_flit(d);
    end
    checks++;
    if (err[0] !== 1'b0) begin failures++; $display("FAIL ovf_before got %b want 0", err[0]); end
    push_flit(rnd_flit());
    checks++;
    if (err[0] !== 1'b1) begin failures++; $display("FAIL ovf_set got %b want 1", err[0]); end
    commit();
    for (int r = 0; r < 4; r++) begin
      int ch;
      ch = $urandom_range(0, NUM_CH - 1);
      for (int j = 0; j < 4; j++) add_exp(ch, q[r*4+j]);
      push_route(ch, 3);
    end
    wait_drain(60);
    checks++;
    if (exp_ch.size() != 0) begin failures++; $display("FAIL ovf_drain pending=%0d want 0", exp_ch.size()); end
    for (int r = 0; r < 5; r++) begin
      int ch;
      ch = $urandom_range(0, NUM_CH - 1);
      push_route(ch, 3);
      for (int j = 0; j < 4; j++) begin
        d = rnd_flit();
        add_exp(ch, d);
        push_flit(d);
      end
      commit();
    end
    wait_drain(60);
    checks++;
    if (exp_ch.size() != 0) begin failures++; $display("FAIL wrap_drain pending=%0d want 0", exp_ch.size()); end
  endtask

  task automatic test_protocol;
    logic [FLIT_W-1:0] d;
    checks++;
    if (err[2] !== 1'b0) begin failures++; $display("FAIL proto_before got %b want 0", err[2]); end
    push_route(1, 0);
    d = rnd_flit();
    add_exp(1, d);
    pars_data_valid = 1;
    pars_data_flit = d;
    bookend_v = 1;
    step();
    checks++;
    if (err[2] !== 1'b1) begin failures++; $display("FAIL proto_set got %b want 1", err[2]); end
    wait_drain(20);
    checks++;
    if (exp_ch.size() != 0) begin failures++; $display("FAIL proto_drain pending=%0d want 0", exp_ch.size()); end
  endtask

  task automatic test_route_overflow;
    for (int i = 0; i < 9; i++) push_route(0, 0);
    checks += 2;
    if (route_ready !== 1'b0) begin failures++; $display("FAIL rq_full_ready got %b want 0", route_ready); end
    if (err[1] !== 1'b0) begin failures++; $display("FAIL rq_ovf_before got %b want 0", err[1]); end
    push_route(1, 0);
    checks++;
    if (err[1] !== 1'b1) begin failures++; $display("FAIL rq_ovf_set got %b want 1", err[1]); end
  endtask

  task automatic test_reset_mid_xfer;
    int s;
    logic [FLIT_W-1:0] d;
    s = obs_t.size();
    for (int i = 0; i < 6; i++) begin
      d = rnd_flit();
      add_exp(0, d);
      push_flit(d);
    end
    commit();
    for (int i = 0; i < 50 && obs_t.size() < s + 2; i++) step();
    #2 reset = 1;
    #1;
    exp_ch.delete();
    exp_d.delete();
    checks += 4;
    if (out_ch_v !== '0) begin failures++; $display("FAIL rst_mid_out_ch_v got %b want 0", out_ch_v); end
    if (out_data !== '0) begin failures++; $display("FAIL rst_mid_out_data got %h want 0", out_data[31:0]); end
    if (route_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_route_ready got %b want 1", route_ready); end
    if (err !== 3'b000) begin failures++; $display("FAIL rst_mid_err got %b want 000", err); end
    @(posedge tlx_clk);
    #3 reset = 0;
    s = obs_t.size();
    repeat (10) step();
    checks++;
    if (obs_t.size() != s) begin failures++; $display("FAIL rst_mid_stale got %0d outputs want 0", obs_t.size() - s); end
  endtask

  initial begin
    test_reset();
    test_commit_deliver();
    test_crc_flush();
    test_hold();
    test_back_to_back();
    test_random();
    test_overflow_wrap();
    test_protocol();
    test_route_overflow();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
